pll_lock_supervisor: RTL and testbench

- Supervises a board PLL wrapper on a free-running reference clock.
- Generates the PLL reset pulse and debounces and qualifies the PLL lock.
- Retries the PLL on lock timeout, up to a limit.
- Releases N downstream clock-domain resets in a fixed staged order once lock is stable, and re-asserts them all on lock loss.
- Sits between the PLL wrapper and the per-domain reset synchronisers in the top level.

---
 rtl/pll_lock_supervisor_if.sv | 18 +
 rtl/pll_lock_supervisor.sv | 96 +++++++++
 tb/tb_pll_lock_supervisor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: lock, retry and reset signals between the PLL wrapper, the supervisor and the domain reset synchronisers
interface pll_lock_supervisor_if #(parameter int N_DOMAINS = 3);
   logic                 pll_lock_in;
   logic                 force_relock;
   logic                 pll_rst;
   logic [N_DOMAINS-1:0] domain_rst;
   logic                 locked_ok;
   logic                 fail;
   logic [3:0]           retry_cnt;
   modport master (
      input  pll_lock_in, force_relock,
      output pll_rst, domain_rst, locked_ok, fail, retry_cnt
   );
   modport slave (
      output pll_lock_in, force_relock,
      input  pll_rst, domain_rst, locked_ok, fail, retry_cnt
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset pulse, lock qualification with retries, and staged release of downstream domain resets
module pll_lock_supervisor #(
   parameter int N_DOMAINS        = 3,
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 1000000,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int STAGE_GAP_CYC    = 64,
   parameter int MAX_RETRY        = 7
) (
   input logic                   clkin1,
   input logic                   rst,
   pll_lock_supervisor_if.master bus
);
   localparam int MAX_AB = RST_PULSE_CYC > LOCK_TIMEOUT_CYC ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
   localparam int MAX_CD = LOCK_STABLE_CYC > STAGE_GAP_CYC ? LOCK_STABLE_CYC : STAGE_GAP_CYC;
   localparam int CW = $clog2(MAX_AB > MAX_CD ? MAX_AB : MAX_CD);

   typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          s1;
   logic          lk;
   logic          restart;
   logic          attempt_failed;
   logic          give_up;
   logic [3:0]    retry_nxt;

   // A fresh sequence (retry budget cleared) starts on a relock request or on lock loss after full release
   assign restart = (bus.force_relock && state != RESET_PLL) || (state == RUN && !lk);
   assign attempt_failed = !lk && (state == STABLE || state == RELEASE ||
                                   (state == WAIT_LOCK && cnt == CW'(LOCK_TIMEOUT_CYC - 1)));
   assign retry_nxt = (bus.retry_cnt < 4'(MAX_RETRY)) ? bus.retry_cnt + 4'd1 : bus.retry_cnt;
   assign give_up = retry_nxt == 4'(MAX_RETRY);

   // Two-flop synchroniser for the lock, which is asynchronous to the reference clock
   always_ff @(posedge clkin1 or posedge rst)
      if (rst) {lk, s1} <= 2'b00;
      else     {lk, s1} <= {s1, bus.pll_lock_in};

   // Sequencer: PLL reset pulse, lock wait, stability qualification, staged release, run and fail
   always_ff @(posedge clkin1 or posedge rst)
      if (rst) begin
         state          <= RESET_PLL;
         cnt            <= '0;
         bus.pll_rst    <= 1'b1;
         bus.domain_rst <= '1;
         bus.locked_ok  <= 1'b0;
         bus.fail       <= 1'b0;
         bus.retry_cnt  <= 4'd0;
      end else if (restart) begin
         state          <= RESET_PLL;
         cnt            <= '0;
         bus.pll_rst    <= 1'b1;
         bus.domain_rst <= '1;
         bus.locked_ok  <= 1'b0;
         bus.fail       <= 1'b0;
         bus.retry_cnt  <= 4'd0;
      end else if (attempt_failed) begin
         state          <= give_up ? FAIL : RESET_PLL;
         cnt            <= '0;
         bus.pll_rst    <= !give_up;
         bus.domain_rst <= '1;
         bus.fail       <= give_up;
         bus.retry_cnt  <= retry_nxt;
      end else begin
         cnt <= cnt + 1'b1;
         case (state)
            RESET_PLL: if (cnt == CW'(RST_PULSE_CYC - 1)) begin
               state       <= WAIT_LOCK;
               cnt         <= '0;
               bus.pll_rst <= 1'b0;
            end
            WAIT_LOCK: if (lk) begin
               state <= STABLE;
               cnt   <= '0;
            end
            STABLE: if (cnt == CW'(LOCK_STABLE_CYC - 1)) begin
               state          <= RELEASE;
               cnt            <= '0;
               bus.domain_rst <= bus.domain_rst << 1;
            end
            RELEASE: if (bus.domain_rst == '0) begin
               state         <= RUN;
               cnt           <= '0;
               bus.locked_ok <= 1'b1;
            end else if (cnt == CW'(STAGE_GAP_CYC - 1)) begin
               cnt            <= '0;
               bus.domain_rst <= bus.domain_rst << 1;
            end
            RUN:     cnt <= '0;
            FAIL:    cnt <= '0;
            default: state <= RESET_PLL;
         endcase
      end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed scenarios checked against a phase/elapsed-time model of the supervisor
module tb_pll_lock_supervisor;
   localparam int ND = 3, PULSE = 4, TO = 100, STAB = 10, GAP = 5, MAXR = 2;
   localparam int PH_PULSE = 0, PH_WAIT = 1, PH_STABLE = 2, PH_REL = 3, PH_RUN = 4, PH_FAIL = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   pll_lock_supervisor_if #(.N_DOMAINS(ND)) bus ();

   pll_lock_supervisor #(
      .N_DOMAINS(ND), .RST_PULSE_CYC(PULSE), .LOCK_TIMEOUT_CYC(TO),
      .LOCK_STABLE_CYC(STAB), .STAGE_GAP_CYC(GAP), .MAX_RETRY(MAXR)
   ) dut (
      .clkin1(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Model: current phase, edges elapsed in it, retry count, and the last two lock samples
   int   ph = PH_PULSE;
   int   t = 0;
   int   m_retry = 0;
   logic h1 = 1'b0, h2 = 1'b0, m_lk = 1'b0;

   task automatic go(int p);
      ph = p;
      t = 0;
   endtask

   task automatic lost_attempt();
      m_retry++;
      go(m_retry == MAXR ? PH_FAIL : PH_PULSE);
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         go(PH_PULSE);
         m_retry = 0;
         h1 = 1'b0;
         h2 = 1'b0;
      end else begin
         m_lk = h2;
         h2 = h1;
         h1 = bus.pll_lock_in;
         t++;
         if (bus.force_relock && ph != PH_PULSE) begin
            m_retry = 0;
            go(PH_PULSE);
         end else case (ph)
            PH_PULSE:  if (t == PULSE) go(PH_WAIT);
            PH_WAIT:   if (m_lk) go(PH_STABLE); else if (t == TO) lost_attempt();
            PH_STABLE: if (!m_lk) lost_attempt(); else if (t == STAB) go(PH_REL);
            PH_REL:    if (!m_lk) lost_attempt(); else if (t == (ND - 1) * GAP + 1) go(PH_RUN);
            PH_RUN:    if (!m_lk) begin m_retry = 0; go(PH_PULSE); end
            default: ;
         endcase
      end
   end

   function automatic logic [9:0] m_out();
      logic [ND-1:0] ones, dom;
      ones = '1;
      dom = (ph == PH_REL) ? ones << (t / GAP + 1) : (ph == PH_RUN) ? '0 : ones;
      return {ph == PH_PULSE, dom, ph == PH_RUN, ph == PH_FAIL, 4'(m_retry)};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {bus.pll_rst, bus.domain_rst, bus.locked_ok, bus.fail, bus.retry_cnt};
   endfunction

   function automatic int sig(int sel);
      return sel == 0 ? int'(bus.pll_rst) : sel == 1 ? int'(bus.domain_rst) :
             sel == 2 ? int'(bus.locked_ok) : sel == 3 ? int'(bus.fail) : int'(bus.retry_cnt);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every cycle, the registered outputs must equal the model
   always @(posedge clk) begin
      #2;
      check("outputs_vs_model", 32'(dut_vec()), 32'(m_out()));
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(string name, int sel, int val, int budget, output int at);
      int n;
      n = 0;
      while (sig(sel) != val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, sig(sel), val);
      at = cyc;
   endtask

   // From a pll_rst rise at cycle start: pulse width, lock 20 cycles after fall, staged release timing
   task automatic nominal(string tag, int start, int exp_retry);
      int f, l, t1, t2, t3, t4;
      wait_until({tag, "_pll_fall"}, 0, 0, 20, f);
      check({tag, "_pulse_width"}, f - start, PULSE);
      tick(20);
      bus.pll_lock_in = 1'b1;
      l = cyc;
      wait_until({tag, "_dom_110"}, 1, 6, 40, t1);
      check({tag, "_lock_to_first_release"}, t1 - l, 13);
      wait_until({tag, "_dom_100"}, 1, 4, 20, t2);
      check({tag, "_gap1"}, t2 - t1, 5);
      wait_until({tag, "_dom_000"}, 1, 0, 20, t3);
      check({tag, "_gap2"}, t3 - t2, 5);
      wait_until({tag, "_locked_ok"}, 2, 1, 5, t4);
      check({tag, "_ok_delay"}, t4 - t3, 1);
      check({tag, "_retry"}, sig(4), exp_retry);
   endtask

   initial begin
      int r0, a, d, f, l, r1, f1, r2, f2, fc;
      logic held;
      bus.pll_lock_in = 1'b0;
      bus.force_relock = 1'b0;
      tick(3);
      check("reset_state", 32'(dut_vec()), 32'(10'b1_111_0_0_0000));
      check("model_reset_state", 32'(m_out()), 32'(10'b1_111_0_0_0000));
      // Scenario 1: nominal bring-up
      rst = 1'b0;
      r0 = cyc;
      nominal("s1", r0, 0);
      // Scenario 4: lock loss in RUN
      tick(5);
      bus.pll_lock_in = 1'b0;
      d = cyc;
      wait_until("s4_dom_reasserted", 1, 7, 5, a);
      check("s4_loss_latency", a - d, 3);
      check("s4_ok_low", sig(2), 0);
      check("s4_pll_rst", sig(0), 1);
      check("s4_retry", sig(4), 0);
      nominal("s4", a, 0);
      // Scenario 3: 3-cycle glitch during STABLE
      tick(3);
      bus.pll_lock_in = 1'b0;
      wait_until("s3_pulse", 0, 1, 5, a);
      wait_until("s3_fall", 0, 0, 10, f);
      tick(5);
      bus.pll_lock_in = 1'b1;
      l = cyc;
      held = 1'b1;
      for (int i = 0; i < 8; i++) begin @(negedge clk); held &= (sig(1) == 7); end
      bus.pll_lock_in = 1'b0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); held &= (sig(1) == 7); end
      bus.pll_lock_in = 1'b1;
      check("s3_glitch_cycle", cyc - l, 11);
      check("s3_repulse", sig(0), 1);
      check("s3_retry", sig(4), 1);
      wait_until("s3_fall2", 0, 0, 10, f);
      check("s3_pulse_width", f - (l + 11), PULSE);
      check("s3_dom_held", held, 1);
      wait_until("s3_run", 2, 1, 60, a);
      check("s3_retry_in_run", sig(4), 1);
      // Scenario 2: no lock at all
      bus.pll_lock_in = 1'b0;
      wait_until("s2_rise1", 0, 1, 5, r1);
      check("s2_retry_cleared", sig(4), 0);
      wait_until("s2_fall1", 0, 0, 10, f1);
      check("s2_width1", f1 - r1, PULSE);
      wait_until("s2_rise2", 0, 1, 110, r2);
      check("s2_timeout1", r2 - f1, TO);
      check("s2_retry1", sig(4), 1);
      wait_until("s2_fall2", 0, 0, 10, f2);
      check("s2_width2", f2 - r2, PULSE);
      wait_until("s2_fail", 3, 1, 110, a);
      check("s2_timeout2", a - f2, TO);
      check("s2_fail_state", 32'(dut_vec()), 32'(10'b0_111_0_1_0010));
      tick(50);
      check("s2_fail_held", 32'(dut_vec()), 32'(10'b0_111_0_1_0010));
      check("model_fail_state", 32'(m_out()), 32'(10'b0_111_0_1_0010));
      // Scenario 5: force_relock out of FAIL; a second request during the pulse is ignored
      bus.force_relock = 1'b1;
      @(negedge clk);
      bus.force_relock = 1'b0;
      fc = cyc;
      check("s5_fail_cleared", sig(3), 0);
      check("s5_retry_cleared", sig(4), 0);
      check("s5_pll_rst", sig(0), 1);
      bus.force_relock = 1'b1;
      @(negedge clk);
      bus.force_relock = 1'b0;
      nominal("s5", fc, 0);
      // Scenario 6: asynchronous reset mid-release
      bus.pll_lock_in = 1'b0;
      wait_until("s6_pulse", 0, 1, 5, a);
      wait_until("s6_fall", 0, 0, 10, f);
      tick(2);
      bus.pll_lock_in = 1'b1;
      wait_until("s6_dom_100", 1, 4, 40, a);
      #3;
      rst = 1'b1;
      #1;
      check("s6_async_reset", 32'(dut_vec()), 32'(10'b1_111_0_0_0000));
      @(negedge clk);
      rst = 1'b0;
      r0 = cyc;
      wait_until("s6_fall_after_reset", 0, 0, 10, f);
      check("s6_pulse_width", f - r0, PULSE);
      wait_until("s6_run", 2, 1, 60, a);
      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
